// File: rtl/read_data_router.sv
// read_data_router
//   Return path for AXI read bursts. Beats from slaves S0, S1 and the default
//   slave SD are routed to master M0 or M1. The destination is the upper
//   nibble of the slave-side RID (0 -> M0, 1 -> M1, anything else -> sink,
//   where beats are accepted and dropped so the slave never hangs).
//   Slaves are arbitrated round-robin; the grant is locked for a whole burst
//   and released on the RLAST handshake.
//
// Handshake: a beat transfers on a cycle where RVALID and RREADY are both
//   high. RVALID from a slave is assumed to stay high until its beat is
//   accepted. Sx_RREADY never rises without Sx_RVALID.
//
// Ports
//   clk, rst                 clock / asynchronous active-high reset
//   S0_*, S1_*, SD_*         slave-side R channels (RID is {master, txn_id})
//   M0_*, M1_*               master-side R channels (RID is txn_id only)
//   dbg_busy                 1 while a burst is locked (FSM state)
//   dbg_rr_ptr               slave with highest priority in the next IDLE
module read_data_router #(
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  S0_RID,
    input  logic [DATA_W-1:0] S0_RDATA,
    input  logic [1:0]        S0_RRESP,
    input  logic              S0_RLAST,
    input  logic              S0_RVALID,
    output logic              S0_RREADY,
    input  logic [IDS_W-1:0]  S1_RID,
    input  logic [DATA_W-1:0] S1_RDATA,
    input  logic [1:0]        S1_RRESP,
    input  logic              S1_RLAST,
    input  logic              S1_RVALID,
    output logic              S1_RREADY,
    input  logic [IDS_W-1:0]  SD_RID,
    input  logic [DATA_W-1:0] SD_RDATA,
    input  logic [1:0]        SD_RRESP,
    input  logic              SD_RLAST,
    input  logic              SD_RVALID,
    output logic              SD_RREADY,
    output logic [ID_W-1:0]   M0_RID,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,
    output logic              M0_RLAST,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,
    output logic [ID_W-1:0]   M1_RID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,
    output logic              M1_RLAST,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,
    output logic              dbg_busy,
    output logic [1:0]        dbg_rr_ptr
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [1:0] TGT_M0   = 2'd0;
    localparam logic [1:0] TGT_M1   = 2'd1;
    localparam logic [1:0] TGT_SINK = 2'd2;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] target_q, target_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    logic [2:0]        s_rvalid;
    logic [1:0]        c0, c1, c2, win;
    logic [IDS_W-1:0]  win_rid;
    logic [IDS_W-1:0]  g_rid;
    logic [DATA_W-1:0] g_data;
    logic [1:0]        g_resp;
    logic              g_last, g_valid;
    logic              g_ready, hs;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign s_rvalid   = {SD_RVALID, S1_RVALID, S0_RVALID};
    assign dbg_busy   = (state_q == BUSY);
    assign dbg_rr_ptr = rr_ptr_q;

    // Round-robin pick: scan from rr_ptr in S0->S1->SD order.
    always_comb begin
        c0 = rr_ptr_q;
        c1 = next_idx(c0);
        c2 = next_idx(c1);
        if (s_rvalid[c0])      win = c0;
        else if (s_rvalid[c1]) win = c1;
        else                   win = c2;
        case (win)
            2'd0:    win_rid = S0_RID;
            2'd1:    win_rid = S1_RID;
            default: win_rid = SD_RID;
        endcase
    end

    // Mux of the granted slave's channel.
    always_comb begin
        case (grant_q)
            2'd0: begin
                g_rid = S0_RID; g_data = S0_RDATA; g_resp = S0_RRESP;
                g_last = S0_RLAST; g_valid = S0_RVALID;
            end
            2'd1: begin
                g_rid = S1_RID; g_data = S1_RDATA; g_resp = S1_RRESP;
                g_last = S1_RLAST; g_valid = S1_RVALID;
            end
            default: begin
                g_rid = SD_RID; g_data = SD_RDATA; g_resp = SD_RRESP;
                g_last = SD_RLAST; g_valid = SD_RVALID;
            end
        endcase
    end

    // Outputs: everything is zero unless BUSY; then the granted slave is
    // passed straight through to the latched target.
    always_comb begin
        M0_RID = '0; M0_RDATA = '0; M0_RRESP = '0; M0_RLAST = 1'b0; M0_RVALID = 1'b0;
        M1_RID = '0; M1_RDATA = '0; M1_RRESP = '0; M1_RLAST = 1'b0; M1_RVALID = 1'b0;
        S0_RREADY = 1'b0;
        S1_RREADY = 1'b0;
        SD_RREADY = 1'b0;
        g_ready   = 1'b0;
        if (state_q == BUSY) begin
            case (target_q)
                TGT_M0: begin
                    M0_RID = g_rid[ID_W-1:0]; M0_RDATA = g_data; M0_RRESP = g_resp;
                    M0_RLAST = g_last; M0_RVALID = g_valid;
                    g_ready = M0_RREADY & g_valid;
                end
                TGT_M1: begin
                    M1_RID = g_rid[ID_W-1:0]; M1_RDATA = g_data; M1_RRESP = g_resp;
                    M1_RLAST = g_last; M1_RVALID = g_valid;
                    g_ready = M1_RREADY & g_valid;
                end
                default: g_ready = g_valid;  // sink: drain without a master
            endcase
            case (grant_q)
                2'd0:    S0_RREADY = g_ready;
                2'd1:    S1_RREADY = g_ready;
                default: SD_RREADY = g_ready;
            endcase
        end
    end

    assign hs = g_ready;  // g_ready already includes g_valid

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        target_d = target_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|s_rvalid) begin
                    grant_d = win;
                    if (win_rid[IDS_W-1:ID_W] == '0)
                        target_d = TGT_M0;
                    else if (win_rid[IDS_W-1:ID_W] == (IDS_W-ID_W)'(1))
                        target_d = TGT_M1;
                    else
                        target_d = TGT_SINK;
                    state_d = BUSY;
                end
            end
            default: begin
                if (hs && g_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(grant_q);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            target_q <= TGT_M0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            target_q <= target_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_read_data_router.sv
module tb_read_data_router;
    typedef struct packed {
        logic [7:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;

    logic [7:0]  s_rid   [3];
    logic [31:0] s_rdata [3];
    logic [1:0]  s_rresp [3];
    logic        s_rlast [3];
    logic [2:0]  s_rvalid;
    logic        s0_rready, s1_rready, sd_rready;
    logic [1:0]  m_rready;

    logic [3:0]  M0_RID, M1_RID;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic [1:0]  M0_RRESP, M1_RRESP;
    logic        M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
    logic        dbg_busy;
    logic [1:0]  dbg_rr_ptr;

    read_data_router dut (
        .clk(clk), .rst(rst),
        .S0_RID(s_rid[0]), .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]),
        .S0_RLAST(s_rlast[0]), .S0_RVALID(s_rvalid[0]), .S0_RREADY(s0_rready),
        .S1_RID(s_rid[1]), .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]),
        .S1_RLAST(s_rlast[1]), .S1_RVALID(s_rvalid[1]), .S1_RREADY(s1_rready),
        .SD_RID(s_rid[2]), .SD_RDATA(s_rdata[2]), .SD_RRESP(s_rresp[2]),
        .SD_RLAST(s_rlast[2]), .SD_RVALID(s_rvalid[2]), .SD_RREADY(sd_rready),
        .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
        .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(m_rready[0]),
        .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
        .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(m_rready[1]),
        .dbg_busy(dbg_busy), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus state ----------------
    beat_t      slv_q [3][$];     // beats each slave still has to deliver
    logic [2:0] cur_valid;        // slave is presenting its head beat

    // ---------------- reference model ----------------
    // Transaction-level view: either idle, or one slave's burst is locked to
    // one destination (0=M0, 1=M1, 2=sink) until its last beat is taken.
    bit         m_busy;
    int         m_grant, m_target, m_ptr;
    logic [39:0] e_bus [2];        // {valid, rid, data, resp, last} per master
    logic [2:0]  e_sready;
    bit          e_hs;
    logic [38:0] exp_q0[$];
    logic [38:0] exp_q1[$];

    function automatic int dest_of(input logic [7:0] rid);
        int nib;
        nib = int'(rid[7:4]);
        return (nib < 2) ? nib : 2;
    endfunction

    task automatic gen_bursts(input int s, input int n);
        int nib_tab [6];
        nib_tab = '{0, 0, 1, 1, 7, 3};
        for (int b = 0; b < n; b++) begin
            int    len;
            beat_t bt;
            len = $urandom_range(1, 5);
            bt.rid = {4'(nib_tab[$urandom_range(0, 5)]), 4'($urandom_range(0, 15))};
            for (int i = 0; i < len; i++) begin
                bt.data = $urandom;
                bt.resp = 2'($urandom_range(0, 3));
                bt.last = (i == len - 1);
                slv_q[s].push_back(bt);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        for (int s = 0; s < 3; s++) begin
            if (!cur_valid[s] && slv_q[s].size() > 0 && $urandom_range(0, 3) != 0)
                cur_valid[s] = 1'b1;
            if (cur_valid[s]) begin
                s_rid[s]   = slv_q[s][0].rid;
                s_rdata[s] = slv_q[s][0].data;
                s_rresp[s] = slv_q[s][0].resp;
                s_rlast[s] = slv_q[s][0].last;
            end else begin
                s_rid[s]   = 8'($urandom);
                s_rdata[s] = $urandom;
                s_rresp[s] = 2'($urandom_range(0, 3));
                s_rlast[s] = 1'($urandom_range(0, 1));
            end
            s_rvalid[s] = cur_valid[s];
        end
        m_rready[0] = ($urandom_range(0, 2) != 0);
        m_rready[1] = ($urandom_range(0, 2) != 0);
    endtask

    task automatic compute_expected();
        e_bus[0] = '0;
        e_bus[1] = '0;
        e_sready = '0;
        e_hs     = 1'b0;
        if (m_busy) begin
            if (m_target < 2) begin
                e_bus[m_target] = {s_rvalid[m_grant], s_rid[m_grant][3:0], s_rdata[m_grant],
                                   s_rresp[m_grant], s_rlast[m_grant]};
                e_sready[m_grant] = m_rready[m_target] & s_rvalid[m_grant];
            end else begin
                e_sready[m_grant] = s_rvalid[m_grant];
            end
            e_hs = e_sready[m_grant];
            if (e_hs && m_target == 0) exp_q0.push_back(e_bus[0][38:0]);
            if (e_hs && m_target == 1) exp_q1.push_back(e_bus[1][38:0]);
        end
    endtask

    task automatic model_step();
        if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (m_ptr + k) % 3;
                if (!m_busy && s_rvalid[s]) begin
                    m_busy   = 1'b1;
                    m_grant  = s;
                    m_target = dest_of(s_rid[s]);
                end
            end
        end else if (e_hs) begin
            void'(slv_q[m_grant].pop_front());
            cur_valid[m_grant] = 1'b0;
            if (s_rlast[m_grant]) begin
                m_busy = 1'b0;
                m_ptr  = (m_grant + 1) % 3;
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("m0_bus", {M0_RVALID, M0_RID, M0_RDATA, M0_RRESP, M0_RLAST}, e_bus[0]);
        check_eq("m1_bus", {M1_RVALID, M1_RID, M1_RDATA, M1_RRESP, M1_RLAST}, e_bus[1]);
        check_eq("s_rready", {sd_rready, s1_rready, s0_rready}, e_sready);
        check_eq("busy", dbg_busy, m_busy);
        check_eq("rr_ptr", dbg_rr_ptr, m_ptr);
        if (M0_RVALID && m_rready[0]) begin
            check_eq("m0_sb_avail", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0)
                check_eq("m0_sb_beat", {M0_RID, M0_RDATA, M0_RRESP, M0_RLAST}, exp_q0.pop_front());
        end
        if (M1_RVALID && m_rready[1]) begin
            check_eq("m1_sb_avail", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0)
                check_eq("m1_sb_beat", {M1_RID, M1_RDATA, M1_RRESP, M1_RLAST}, exp_q1.pop_front());
        end
    endtask

    function automatic bit work_left();
        return m_busy || slv_q[0].size() != 0 || slv_q[1].size() != 0 || slv_q[2].size() != 0;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int cycles;
        int resets;
        rst       = 1'b1;
        cur_valid = '0;
        s_rvalid  = '0;
        m_rready  = '0;
        for (int s = 0; s < 3; s++) begin
            s_rid[s] = '0; s_rdata[s] = '0; s_rresp[s] = '0; s_rlast[s] = 1'b0;
        end
        m_busy = 1'b0; m_grant = 0; m_target = 0; m_ptr = 0;

        // Reset state: all outputs zero, idle, pointer at S0.
        #3;
        compute_expected();
        compare_outputs();

        for (int s = 0; s < 3; s++) gen_bursts(s, 30);

        @(posedge clk);
        #1;
        rst = 1'b0;

        cycles = 0;
        resets = 0;
        while (work_left() && cycles < 20000) begin
            drive_inputs();
            if (m_busy && resets < 6 && $urandom_range(0, 60) == 0) begin
                // Mid-burst reset: outputs drop at once, partial burst is lost.
                rst    = 1'b1;
                resets++;
                m_busy = 1'b0;
                m_ptr  = 0;
                compute_expected();
                #2;
                compare_outputs();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                compute_expected();
                @(negedge clk);
                compare_outputs();
                model_step();
                @(posedge clk);
                #1;
            end
            cycles++;
        end

        check_eq("drained_in_budget", work_left(), 0);
        check_eq("m0_sb_leftover", exp_q0.size(), 0);
        check_eq("m1_sb_leftover", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
